cpu_mem_arbiter: RTL and testbench

Shares the single memory port of `cpu_test_top` between the custom CPU's instruction-fetch and data-access requesters. Each upstream request is accepted with a valid/ready handshake and replayed on the downstream port; reads then route the downstream response back to the owning requester. There is one outstanding transaction at a time, and grants between the two requesters are round-robin.

---
 rtl/cpu_mem_arb_pkg.sv | 27 ++
 rtl/cpu_mem_arb_rr2.sv | 41 ++++
 rtl/cpu_mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_arb_pkg.sv
// cpu_mem_arb_pkg: shared encodings for the CPU memory-port arbiter.
// FSM states and requester identities are used by the top and the
// round-robin picker so both agree on the encoding.
package cpu_mem_arb_pkg;

   // Arbiter FSM: idle/arbitrating, presenting downstream request,
   // forwarding the read response.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   // Requester identity, used both for the transaction owner and for
   // the round-robin history.
   typedef enum logic {
      INST = 1'b0,
      DATA = 1'b1
   } arb_owner_e;

   // Width of the optional event counters.
   localparam int unsigned PERF_CNT_W = 32;

   // Increment constant at counter width, avoids mixed-width adds.
   localparam logic [PERF_CNT_W-1:0] PERF_CNT_ONE = 1;

endpackage

// File: rtl/cpu_mem_arb_rr2.sv
// cpu_mem_arb_rr2: 2-way round-robin picker.
// grant[0] selects the instruction requester, grant[1] the data requester.
// On a tie the requester that did not win last time is chosen. The
// history update is returned as last_grant_nxt so the owning module keeps
// the register alongside its other reset state.
module cpu_mem_arb_rr2
   import cpu_mem_arb_pkg::*;
(
   input  logic       req_inst,
   input  logic       req_data,
   input  arb_owner_e last_grant,
   input  logic       update_en,
   output logic [1:0] grant,
   output arb_owner_e last_grant_nxt
);

   // One-hot grant: a lone requester wins; a tie goes to the one not granted last.
   always_comb begin
      grant = 2'b00;
      if (req_inst && req_data) begin
         grant = (last_grant == DATA) ? 2'b01 : 2'b10;
      end else if (req_inst) begin
         grant = 2'b01;
      end else if (req_data) begin
         grant = 2'b10;
      end
   end

   // History advances only when the grant is actually consumed by a handshake.
   always_comb begin
      last_grant_nxt = last_grant;
      if (update_en) begin
         if (grant[1]) begin
            last_grant_nxt = DATA;
         end else if (grant[0]) begin
            last_grant_nxt = INST;
         end
      end
   end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one memory port between instruction fetch and
// data access. One transaction is in flight at a time; ties between the
// two requesters are broken round-robin. Loads route the downstream
// response back combinationally to the requester that issued them; stores
// complete on the downstream handshake with no upstream response.
// Optional build macro: CPU_MEM_ARB_PERF_CNT_EN adds three 32-bit event
// counters (grants per requester and conflict cycles).
module cpu_mem_arbiter
   import cpu_mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    sys_clk,
   input  logic                    sys_reset_n,

   input  logic                    inst_req_valid,
   output logic                    inst_req_ready,
   input  logic [ADDR_WIDTH-1:0]   inst_req_addr,
   output logic                    inst_resp_valid,
   input  logic                    inst_resp_ready,
   output logic [DATA_WIDTH-1:0]   inst_resp_data,

   input  logic                    data_req_valid,
   output logic                    data_req_ready,
   input  logic [ADDR_WIDTH-1:0]   data_req_addr,
   input  logic                    data_req_wen,
   input  logic [DATA_WIDTH/8-1:0] data_req_wstrb,
   input  logic [DATA_WIDTH-1:0]   data_req_wdata,
   output logic                    data_resp_valid,
   input  logic                    data_resp_ready,
   output logic [DATA_WIDTH-1:0]   data_resp_data,

   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [ADDR_WIDTH-1:0]   mem_req_addr,
   output logic                    mem_req_wen,
   output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
   output logic [DATA_WIDTH-1:0]   mem_req_wdata,
   input  logic                    mem_resp_valid,
   output logic                    mem_resp_ready,
   input  logic [DATA_WIDTH-1:0]   mem_resp_data
`ifdef CPU_MEM_ARB_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0]   perf_inst_grants,
   output logic [PERF_CNT_W-1:0]   perf_data_grants,
   output logic [PERF_CNT_W-1:0]   perf_conflict_cycles
`endif
);

   localparam int STRB_W = DATA_WIDTH / 8;

   arb_state_e            state_q;
   arb_state_e            state_d;
   arb_owner_e            last_grant_q;
   arb_owner_e            last_grant_d;
   logic [1:0]            grant;
   logic                  in_idle;
   logic                  accept_inst;
   logic                  accept_data;
   logic                  accept_any;

   // Captured request, held for the whole transaction.
   arb_owner_e            req_owner_p1;
   logic [ADDR_WIDTH-1:0] req_addr_p1;
   logic                  req_wen_p1;
   logic [STRB_W-1:0]     req_wstrb_p1;
   logic [DATA_WIDTH-1:0] req_wdata_p1;

   assign in_idle     = (state_q == IDLE);
   assign accept_inst = in_idle & inst_req_valid & grant[0];
   assign accept_data = in_idle & data_req_valid & grant[1];
   assign accept_any  = accept_inst | accept_data;

   cpu_mem_arb_rr2 u_rr2 (
      .req_inst       (inst_req_valid),
      .req_data       (data_req_valid),
      .last_grant     (last_grant_q),
      .update_en      (accept_any),
      .grant          (grant),
      .last_grant_nxt (last_grant_d)
   );

   // FSM state register.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; nothing is accepted outside IDLE.
   always_comb begin
      state_d         = state_q;
      inst_req_ready  = 1'b0;
      data_req_ready  = 1'b0;
      mem_req_valid   = 1'b0;
      mem_resp_ready  = 1'b0;
      inst_resp_valid = 1'b0;
      data_resp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            inst_req_ready = grant[0];
            data_req_ready = grant[1];
            if (accept_any) begin
               state_d = REQ;
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_d = req_wen_p1 ? IDLE : RESP;
            end
         end
         RESP: begin
            if (req_owner_p1 == INST) begin
               inst_resp_valid = mem_resp_valid;
               mem_resp_ready  = inst_resp_ready;
            end else begin
               data_resp_valid = mem_resp_valid;
               mem_resp_ready  = data_resp_ready;
            end
            if (mem_resp_valid && mem_resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Round-robin history; starts at DATA so the first tie goes to fetch.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         last_grant_q <= DATA;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   // ---- capture stage: upstream handshake -> registered downstream request ----
   // Fetches never write, so their write fields are forced to zero.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         req_owner_p1 <= INST;
         req_addr_p1  <= '0;
         req_wen_p1   <= 1'b0;
         req_wstrb_p1 <= '0;
         req_wdata_p1 <= '0;
      end else if (accept_inst) begin
         req_owner_p1 <= INST;
         req_addr_p1  <= inst_req_addr;
         req_wen_p1   <= 1'b0;
         req_wstrb_p1 <= '0;
         req_wdata_p1 <= '0;
      end else if (accept_data) begin
         req_owner_p1 <= DATA;
         req_addr_p1  <= data_req_addr;
         req_wen_p1   <= data_req_wen;
         req_wstrb_p1 <= data_req_wstrb;
         req_wdata_p1 <= data_req_wdata;
      end
   end

   assign mem_req_addr  = req_addr_p1;
   assign mem_req_wen   = req_wen_p1;
   assign mem_req_wstrb = req_wstrb_p1;
   assign mem_req_wdata = req_wdata_p1;

   // Read data passes straight through; the valids above pick the recipient.
   assign inst_resp_data = mem_resp_data;
   assign data_resp_data = mem_resp_data;

`ifdef CPU_MEM_ARB_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] perf_inst_cnt_q;
   logic [PERF_CNT_W-1:0] perf_data_cnt_q;
   logic [PERF_CNT_W-1:0] perf_conf_cnt_q;
   logic                  conflict;

   assign conflict = in_idle & inst_req_valid & data_req_valid;

   // Event counters; they wrap naturally at 2^32.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         perf_inst_cnt_q <= '0;
         perf_data_cnt_q <= '0;
         perf_conf_cnt_q <= '0;
      end else begin
         if (accept_inst) begin
            perf_inst_cnt_q <= perf_inst_cnt_q + PERF_CNT_ONE;
         end
         if (accept_data) begin
            perf_data_cnt_q <= perf_data_cnt_q + PERF_CNT_ONE;
         end
         if (conflict) begin
            perf_conf_cnt_q <= perf_conf_cnt_q + PERF_CNT_ONE;
         end
      end
   end

   assign perf_inst_grants     = perf_inst_cnt_q;
   assign perf_data_grants     = perf_data_cnt_q;
   assign perf_conflict_cycles = perf_conf_cnt_q;
`endif

   // Downstream request must hold still until the memory takes it.
   a_req_hold: assert property (@(posedge sys_clk) disable iff (!sys_reset_n)
      (mem_req_valid && !mem_req_ready) |=>
         (mem_req_valid && $stable(mem_req_addr) && $stable(mem_req_wen) &&
          $stable(mem_req_wstrb) && $stable(mem_req_wdata)));

   // At most one requester may ever see ready.
   a_one_ready: assert property (@(posedge sys_clk) disable iff (!sys_reset_n)
      !(inst_req_ready && data_req_ready));

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: randomized scoreboard bench for cpu_mem_arbiter.
// Requester tasks push expected downstream requests and load data (from a
// word-level reference memory) into queues at accept time; a negedge
// monitor pops and compares as the DUT presents them, and also checks the
// arbitration and one-at-a-time rules.
module tb_cpu_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int M_RAND = 0;
   localparam int M_HIGH = 1;
   localparam int M_LOW  = 2;

   logic          sys_clk = 1'b0;
   logic          sys_reset_n;
   logic          inst_req_valid, inst_req_ready;
   logic [AW-1:0] inst_req_addr;
   logic          inst_resp_valid, inst_resp_ready;
   logic [DW-1:0] inst_resp_data;
   logic          data_req_valid, data_req_ready;
   logic [AW-1:0] data_req_addr;
   logic          data_req_wen;
   logic [SW-1:0] data_req_wstrb;
   logic [DW-1:0] data_req_wdata;
   logic          data_resp_valid, data_resp_ready;
   logic [DW-1:0] data_resp_data;
   logic          mem_req_valid, mem_req_ready;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_wen;
   logic [SW-1:0] mem_req_wstrb;
   logic [DW-1:0] mem_req_wdata;
   logic          mem_resp_valid, mem_resp_ready;
   logic [DW-1:0] mem_resp_data;
`ifdef CPU_MEM_ARB_PERF_CNT_EN
   logic [31:0]   perf_inst_grants, perf_data_grants, perf_conflict_cycles;
`endif

   always #5 sys_clk = ~sys_clk;

   cpu_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
      .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
      .inst_req_addr(inst_req_addr),
      .inst_resp_valid(inst_resp_valid), .inst_resp_ready(inst_resp_ready),
      .inst_resp_data(inst_resp_data),
      .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
      .data_req_addr(data_req_addr), .data_req_wen(data_req_wen),
      .data_req_wstrb(data_req_wstrb), .data_req_wdata(data_req_wdata),
      .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready),
      .data_resp_data(data_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_resp_data(mem_resp_data)
`ifdef CPU_MEM_ARB_PERF_CNT_EN
      ,
      .perf_inst_grants(perf_inst_grants), .perf_data_grants(perf_data_grants),
      .perf_conflict_cycles(perf_conflict_cycles)
`endif
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic          wen;
      logic [SW-1:0] wstrb;
      logic [DW-1:0] wdata;
   } req_t;

   int            vectors = 0;
   int            miscompares = 0;
   req_t          req_q[$];
   logic [DW-1:0] inst_q[$];
   logic [DW-1:0] data_q[$];
   int            grant_log[$];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic [DW-1:0] slave_mem [logic [AW-1:0]];
   bit            busy = 1'b0;
   int            last_winner = 1;
   logic [DW-1:0] last_inst_resp = '0;
   logic [DW-1:0] last_data_resp = '0;
   int            n_data_resp = 0;
   int            rdy_mode = M_HIGH;
   int            slv_rdy_mode = M_HIGH;
   int            slv_delay = 0;
   bit            slv_pend = 1'b0;
   int            slv_cnt = 0;
   logic [DW-1:0] slv_rdata = '0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endfunction

   function automatic void fail_timeout(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                           input logic [SW-1:0] st);
      logic [DW-1:0] r = old;
      for (int b = 0; b < SW; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : '0;
   endfunction

   function automatic logic [DW-1:0] slv_rd(input logic [AW-1:0] a);
      return slave_mem.exists(a) ? slave_mem[a] : '0;
   endfunction

   function automatic logic ready_of(input int mode);
      if (mode == M_RAND) return 1'($urandom_range(0, 1));
      return (mode == M_HIGH);
   endfunction

   // Fetch request; records expectations when the handshake is seen.
   task automatic inst_txn(input logic [AW-1:0] a);
      int n = 0;
      inst_req_addr  = a;
      inst_req_valid = 1'b1;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!(inst_req_ready && sys_reset_n) && n < 300);
      if (n >= 300) fail_timeout("inst_accept");
      else begin
         req_q.push_back('{a, 1'b0, '0, '0});
         inst_q.push_back(ref_rd(a));
      end
      @(posedge sys_clk); #1;
      inst_req_valid = 1'b0;
      inst_req_addr  = $urandom;
   endtask

   // Load/store request; stores update the reference memory at accept.
   task automatic data_txn(input logic [AW-1:0] a, input logic w, input logic [SW-1:0] st,
                           input logic [DW-1:0] wd);
      int n = 0;
      data_req_addr  = a;
      data_req_wen   = w;
      data_req_wstrb = st;
      data_req_wdata = wd;
      data_req_valid = 1'b1;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!(data_req_ready && sys_reset_n) && n < 300);
      if (n >= 300) fail_timeout("data_accept");
      else begin
         req_q.push_back('{a, w, st, wd});
         if (w) ref_mem[a] = merge(ref_rd(a), wd, st);
         else data_q.push_back(ref_rd(a));
      end
      @(posedge sys_clk); #1;
      data_req_valid = 1'b0;
      data_req_wdata = $urandom;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      do begin
         @(negedge sys_clk); #1;
         n++;
      end while ((busy || req_q.size() != 0 || inst_q.size() != 0 || data_q.size() != 0 ||
                  inst_req_valid || data_req_valid) && n < 500);
      if (n >= 500) fail_timeout(nm);
   endtask

   task automatic wait_inst_resp(input string nm);
      int n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!inst_resp_valid && n < 100);
      if (n >= 100) fail_timeout(nm);
   endtask

   // Downstream memory model: applies stores, answers loads after a delay.
   initial begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      forever begin
         @(negedge sys_clk);
         if (!sys_reset_n) begin
            slv_pend = 1'b0;
         end else begin
            if (mem_resp_valid && mem_resp_ready) slv_pend = 1'b0;
            if (mem_req_valid && mem_req_ready) begin
               if (mem_req_wen) begin
                  slave_mem[mem_req_addr] = merge(slv_rd(mem_req_addr), mem_req_wdata, mem_req_wstrb);
               end else begin
                  slv_pend  = 1'b1;
                  slv_rdata = slv_rd(mem_req_addr);
                  slv_cnt   = (slv_delay < 0) ? int'($urandom_range(0, 3)) : slv_delay;
               end
            end
         end
         @(posedge sys_clk); #1;
         mem_req_ready = ready_of(slv_rdy_mode);
         if (slv_pend && slv_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = slv_rdata;
         end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (slv_pend) slv_cnt--;
         end
      end
   end

   // Upstream response-ready drivers.
   initial begin
      inst_resp_ready = 1'b1;
      data_resp_ready = 1'b1;
      forever begin
         @(posedge sys_clk); #1;
         inst_resp_ready = ready_of(rdy_mode);
         data_resp_ready = ready_of(rdy_mode);
      end
   end

   // Monitor / scoreboard.
   always @(negedge sys_clk) begin
      logic ia, da;
      int   want;
      if (!sys_reset_n) begin
         busy        = 1'b0;
         last_winner = 1;
      end else begin
         ia = inst_req_valid && inst_req_ready;
         da = data_req_valid && data_req_ready;
         if (busy) begin
            chk("ready_while_busy", {30'd0, inst_req_ready, data_req_ready}, 32'd0);
         end else if (inst_req_valid || data_req_valid) begin
            if (inst_req_valid && data_req_valid) want = (last_winner == 1) ? 0 : 1;
            else want = inst_req_valid ? 0 : 1;
            chk("arb_winner", {30'd0, ia, da}, (want == 0) ? 32'd2 : 32'd1);
         end
         if (ia || da) begin
            busy        = 1'b1;
            last_winner = da ? 1 : 0;
            grant_log.push_back(da ? 1 : 0);
         end
         chk("resp_both_valid", {31'd0, inst_resp_valid && data_resp_valid}, 32'd0);
         if (mem_req_valid) begin
            if (req_q.size() == 0) begin
               chk("mem_req_unexpected", 32'd1, 32'd0);
            end else begin
               chk("mem_req_addr", mem_req_addr, req_q[0].addr);
               chk("mem_req_wen", {31'd0, mem_req_wen}, {31'd0, req_q[0].wen});
               chk("mem_req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, req_q[0].wstrb});
               if (req_q[0].wen) chk("mem_req_wdata", mem_req_wdata, req_q[0].wdata);
               if (mem_req_ready) begin
                  if (req_q[0].wen) busy = 1'b0;
                  req_q.delete(0);
               end
            end
         end
         if (inst_resp_valid && inst_resp_ready) begin
            if (inst_q.size() == 0) chk("inst_resp_unexpected", 32'd1, 32'd0);
            else begin
               chk("inst_resp_data", inst_resp_data, inst_q[0]);
               inst_q.delete(0);
            end
            last_inst_resp = inst_resp_data;
            busy = 1'b0;
         end
         if (data_resp_valid && data_resp_ready) begin
            if (data_q.size() == 0) chk("data_resp_unexpected", 32'd1, 32'd0);
            else begin
               chk("data_resp_data", data_resp_data, data_q[0]);
               data_q.delete(0);
            end
            last_data_resp = data_resp_data;
            n_data_resp++;
            busy = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nresp;
      int exp_order[4];
      exp_order = '{0, 1, 0, 1};
      sys_reset_n    = 1'b0;
      inst_req_valid = 1'b0;
      inst_req_addr  = '0;
      data_req_valid = 1'b0;
      data_req_addr  = '0;
      data_req_wen   = 1'b0;
      data_req_wstrb = '0;
      data_req_wdata = '0;
      #1;
      chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_mem_req_addr", mem_req_addr, 32'd0);
      chk("rst_mem_req_wen", {31'd0, mem_req_wen}, 32'd0);
      chk("rst_mem_req_wstrb", {28'd0, mem_req_wstrb}, 32'd0);
      chk("rst_mem_req_wdata", mem_req_wdata, 32'd0);
      chk("rst_resp_valids", {30'd0, inst_resp_valid, data_resp_valid}, 32'd0);
      chk("rst_mem_resp_ready", {31'd0, mem_resp_ready}, 32'd0);
      repeat (3) @(negedge sys_clk);
      sys_reset_n = 1'b1;
      @(posedge sys_clk); #1;

      // Simultaneous requests out of reset: INST, DATA, INST, DATA.
      grant_log.delete();
      fork
         begin inst_txn(32'h10); inst_txn(32'h14); end
         begin data_txn(32'h20, 1'b0, 4'hF, '0); data_txn(32'h24, 1'b0, 4'hF, '0); end
      join
      wait_idle("tie_idle");
      chk("tie_count", grant_log.size(), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < grant_log.size()) chk($sformatf("tie_order_%0d", k), grant_log[k], exp_order[k]);
      end
`ifdef CPU_MEM_ARB_PERF_CNT_EN
      chk("perf_conflict_nonzero", {31'd0, perf_conflict_cycles > 0}, 32'd1);
`endif

      // Fetch only, response two cycles after the downstream accept.
      ref_mem[32'h100]   = 32'h1234_5678;
      slave_mem[32'h100] = 32'h1234_5678;
      slv_delay = 2;
      inst_txn(32'h100);
      wait_idle("fetch_idle");
      chk("fetch_data", last_inst_resp, 32'h1234_5678);

      // Store then load of the same word.
      slv_delay = 0;
      nresp = n_data_resp;
      data_txn(32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF);
      wait_idle("store_idle");
      chk("store_no_resp", n_data_resp - nresp, 32'd0);
      data_txn(32'h200, 1'b0, 4'hF, '0);
      wait_idle("load_idle");
      chk("load_after_store", last_data_resp, 32'h0000_BEEF);

      // Backpressure: downstream not ready for 5 cycles, then response held 3.
      slv_rdy_mode = M_LOW;
      rdy_mode     = M_LOW;
      inst_txn(32'h40);
      fork
         data_txn(32'h44, 1'b0, 4'hF, '0);
      join_none
      repeat (5) begin
         @(negedge sys_clk);
         chk("bp_req_held", {31'd0, mem_req_valid}, 32'd1);
         chk("bp_no_grant", {30'd0, inst_req_ready, data_req_ready}, 32'd0);
      end
      slv_rdy_mode = M_HIGH;
      wait_inst_resp("bp_resp");
      repeat (3) begin
         @(negedge sys_clk);
         chk("bp_resp_held", {31'd0, inst_resp_valid}, 32'd1);
         chk("bp_resp_no_grant", {31'd0, data_req_ready}, 32'd0);
      end
      rdy_mode = M_HIGH;
      wait_idle("bp_idle");

      // Randomized traffic from both requesters over a small address window.
      rdy_mode     = M_RAND;
      slv_rdy_mode = M_RAND;
      slv_delay    = -1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge sys_clk);
               #1;
               inst_txn(32'($urandom_range(0, 15)) << 2);
            end
         end
         begin
            for (int j = 0; j < 40; j++) begin
               repeat ($urandom_range(0, 3)) @(posedge sys_clk);
               #1;
               data_txn(32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), $urandom);
            end
         end
      join
      rdy_mode = M_HIGH;
      wait_idle("rand_idle");

      // Reset while a load response is being held.
      slv_rdy_mode = M_HIGH;
      slv_delay    = 0;
      rdy_mode     = M_LOW;
      inst_txn(32'h300);
      wait_inst_resp("rst_resp_wait");
      @(posedge sys_clk); #2;
      sys_reset_n = 1'b0;
      #1;
      chk("midrst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("midrst_inst_resp_valid", {31'd0, inst_resp_valid}, 32'd0);
      chk("midrst_data_resp_valid", {31'd0, data_resp_valid}, 32'd0);
      chk("midrst_mem_resp_ready", {31'd0, mem_resp_ready}, 32'd0);
      chk("midrst_mem_req_addr", mem_req_addr, 32'd0);
      req_q.delete();
      inst_q.delete();
      data_q.delete();
      repeat (2) @(negedge sys_clk);
      rdy_mode = M_HIGH;
      @(posedge sys_clk); #1;
      sys_reset_n = 1'b1;
      inst_req_addr  = 32'h304;
      inst_req_valid = 1'b1;
      #1;
      chk("post_rst_ready", {31'd0, inst_req_ready}, 32'd1);
      inst_txn(32'h304);
      data_txn(32'h304, 1'b0, 4'hF, '0);
      wait_idle("post_rst_idle");

`ifdef CPU_MEM_ARB_PERF_CNT_EN
      // Counter wrap.
      @(posedge sys_clk); #1;
      force dut.perf_inst_cnt_q = 32'hFFFF_FFFF;
      @(negedge sys_clk);
      release dut.perf_inst_cnt_q;
      inst_txn(32'h8);
      wait_idle("wrap_idle");
      chk("perf_inst_wrap", perf_inst_grants, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
